meta_write_rr_scheduler: RTL and testbench

Round-robin scheduler that shares the single data-cache metadata-array write port among eight requesters: the miss/refill handlers, the prober and the writeback unit. It replaces fixed-priority selection with a fair rotating grant, adds a one-entry registered output stage so the array write port sees a clean, registered request, and flags malformed way masks. The block sits between the requesters and the metadata array write interface.

---
 rtl/meta_write_pkg.sv | 28 ++
 rtl/meta_write_rr_scheduler_rr_pick.sv | 29 ++
 rtl/meta_write_rr_scheduler.sv | 62 ++++++
 tb/tb_meta_write_rr_scheduler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/meta_write_pkg.sv
// Shared types and constants for the metadata-array write scheduler.
// Payload layout and coherence-state encoding used by all requesters.
package meta_write_pkg;

  localparam int DEF_N_REQ = 8;
  localparam int IDX_W     = 6;
  localparam int N_WAYS    = 8;
  localparam int TAG_W     = 20;

  localparam logic [1:0] COH_NOTHING = 2'd0;
  localparam logic [1:0] COH_BRANCH  = 2'd1;
  localparam logic [1:0] COH_TRUNK   = 2'd2;
  localparam logic [1:0] COH_DIRTY   = 2'd3;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [N_WAYS-1:0] way_en;
    logic [1:0]        coh_state;
    logic [TAG_W-1:0]  tag;
  } meta_write_req_t;

  function automatic logic way_ok(
    input logic [N_WAYS-1:0] way_en
  );
    return $countones(way_en) == 1;
  endfunction

endpackage

// File: rtl/meta_write_rr_scheduler_rr_pick.sv
// Combinational circular priority picker starting at ptr.
// Lowest set bit of {valid, valid-at-or-above-ptr} gives the grant.
module rr_pick #(
  parameter  int N  = 8,
  localparam int LW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [LW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [LW-1:0] idx,
  output logic          any
);

  logic [N-1:0]   upper;
  logic [2*N-1:0] dbl;

  always_comb begin
    upper = valid & ~((N'(1) << ptr) - N'(1));
    dbl   = {valid, upper};
    any   = |valid;
    idx   = '0;
    // descending scan so the lowest set bit wins; upper half folds mod N
    for (int i = 2*N-1; i >= 0; i--) begin
      if (dbl[i]) idx = LW'(i);
    end
    grant = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/meta_write_rr_scheduler.sv
// Round-robin arbiter for the metadata-array write port with a
// one-entry registered output stage and a sticky bad-way-mask flag.
module meta_write_rr_scheduler
  import meta_write_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  localparam int SW    = $clog2(N_REQ)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_REQ-1:0] io_in_valid,
  output logic [N_REQ-1:0] io_in_ready,
  input  meta_write_req_t io_in_bits [N_REQ],
  output logic            io_out_valid,
  input  logic            io_out_ready,
  output meta_write_req_t io_out_bits,
  output logic [SW-1:0]   io_out_src,
  output logic            io_err_way
);

  logic [SW-1:0]    ptr;
  logic [N_REQ-1:0] grant;
  logic [SW-1:0]    gidx;
  logic             any;
  logic             can_load;
  logic             fire;

  rr_pick #(
    .N(N_REQ)
  ) u_pick (
    .valid(io_in_valid),
    .ptr  (ptr),
    .grant(grant),
    .idx  (gidx),
    .any  (any)
  );

  assign can_load = !io_out_valid || io_out_ready;
  // ready is held low while reset is asserted, not just after it
  assign io_in_ready = (reset && can_load) ? grant : '0;
  assign fire = reset && can_load && any;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_out_valid <= 1'b0;
      io_out_bits  <= '0;
      io_out_src   <= '0;
      ptr          <= '0;
      io_err_way   <= 1'b0;
    end else if (fire) begin
      io_out_valid <= 1'b1;
      io_out_bits  <= io_in_bits[gidx];
      io_out_src   <= gidx;
      ptr          <= gidx + SW'(1);
      if (!way_ok(io_in_bits[gidx].way_en))
        io_err_way <= 1'b1;
    end else if (io_out_ready) begin
      io_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_meta_write_rr_scheduler.sv
// Bench for meta_write_rr_scheduler: directed scenarios plus random
// traffic, checked every cycle against a queue-free behavioural model.
module tb_meta_write_rr_scheduler;
  import meta_write_pkg::*;

  localparam int N = 8;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  meta_write_req_t in_bits [N];
  logic            out_valid;
  logic            out_ready;
  meta_write_req_t out_bits;
  logic [2:0]      out_src;
  logic            err_way;

  always #5 clock = ~clock;

  meta_write_rr_scheduler #(
    .N_REQ(N)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .io_in_valid (in_valid),
    .io_in_ready (in_ready),
    .io_in_bits  (in_bits),
    .io_out_valid(out_valid),
    .io_out_ready(out_ready),
    .io_out_bits (out_bits),
    .io_out_src  (out_src),
    .io_err_way  (err_way)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic            m_ov;
  meta_write_req_t m_bits;
  int              m_src;
  int              m_ptr;
  logic            m_err;
  logic [N-1:0]    fired;
  int              waits [N];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ov   = 1'b0;
    m_bits = '0;
    m_src  = 0;
    m_ptr  = 0;
    m_err  = 1'b0;
  endtask

  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic cycle();
    int g;
    logic can;
    logic [N-1:0] er;
    #1;
    g   = model_grant();
    can = !m_ov || out_ready;
    er  = '0;
    if (can && g >= 0) er[g] = 1'b1;
    chk("ready", 64'(in_ready), 64'(er));
    fired = in_ready & in_valid;
    @(posedge clock);
    if (can && g >= 0) begin
      m_ov   = 1'b1;
      m_bits = in_bits[g];
      m_src  = g;
      m_ptr  = (g + 1) % N;
      if ($countones(in_bits[g].way_en) != 1) m_err = 1'b1;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("out_src", 64'(out_src), 64'(m_src));
    chk("out_bits", 64'(out_bits), 64'(m_bits));
    chk("err_way", 64'(err_way), 64'(m_err));
  endtask

  meta_write_req_t saved;

  initial begin
    model_reset();
    in_valid  = '0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_bits[i] = '{idx: 6'(i), way_en: 8'(1 << i),
                     coh_state: COH_BRANCH, tag: 20'(i * 3 + 1)};
      waits[i] = 0;
    end

    // reset values, with ready gated even though valid is high
    #2 in_valid = 8'hFF;
    #1;
    chk("rst_ready", 64'(in_ready), 64'h0);
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_src", 64'(out_src), 64'h0);
    chk("rst_bits", 64'(out_bits), 64'h0);
    chk("rst_err", 64'(err_way), 64'h0);
    in_valid = '0;
    @(posedge clock);
    #1 reset = 1'b1;

    // circular search from ptr
    in_valid = 8'b1010_0000;
    #1 chk("t1_ready_a", 64'(in_ready), 64'h20);
    cycle();
    chk("t1_src_a", 64'(out_src), 64'd5);
    #1 chk("t1_ready_b", 64'(in_ready), 64'h80);
    cycle();
    chk("t1_src_b", 64'(out_src), 64'd7);
    #1 chk("t1_ready_c", 64'(in_ready), 64'h20);
    cycle();
    chk("t1_src_c", 64'(out_src), 64'd5);

    // move ptr back to 0, then full-throughput rotation
    in_valid = 8'h80;
    cycle();
    in_valid = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      cycle();
      chk("t2_src", 64'(out_src), 64'(i % 8));
      chk("t2_valid", 64'(out_valid), 64'h1);
    end

    // output stall
    in_valid = 8'h04;
    cycle();
    saved     = out_bits;
    in_valid  = 8'h0C;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t3_ready_stall", 64'(in_ready), 64'h0);
      cycle();
      chk("t3_bits_hold", 64'(out_bits), 64'(saved));
      chk("t3_src_hold", 64'(out_src), 64'd2);
    end
    out_ready = 1'b1;
    #1 chk("t3_ready_release", 64'(in_ready), 64'h08);
    cycle();
    chk("t3_src_next", 64'(out_src), 64'd3);
    chk("t3_valid_next", 64'(out_valid), 64'h1);

    // payload integrity
    in_valid   = 8'h10;
    in_bits[4] = '{idx: 6'h2A, way_en: 8'h10,
                   coh_state: COH_DIRTY, tag: 20'hABCDE};
    cycle();
    chk("t4_bits", 64'(out_bits),
        64'({6'h2A, 8'h10, 2'd3, 20'hABCDE}));
    chk("t4_src", 64'(out_src), 64'd4);
    chk("t4_err", 64'(err_way), 64'h0);

    // bad way mask is sticky
    in_valid = 8'h02;
    in_bits[1].way_en = 8'h06;
    cycle();
    chk("t5_err_set", 64'(err_way), 64'h1);
    in_bits[1].way_en = 8'h01;
    cycle();
    chk("t5_err_stick", 64'(err_way), 64'h1);
    in_valid = '0;
    cycle();

    // asynchronous reset with a stalled pending output
    in_valid = 8'h08;
    cycle();
    out_ready = 1'b0;
    in_valid  = '0;
    #2 reset = 1'b0;
    #1;
    chk("t6_valid_drop", 64'(out_valid), 64'h0);
    chk("t6_err_clr", 64'(err_way), 64'h0);
    chk("t6_src_clr", 64'(out_src), 64'h0);
    model_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    out_ready = 1'b1;
    in_valid  = 8'h41;
    #1 chk("t6_ready_first", 64'(in_ready), 64'h01);
    cycle();
    chk("t6_src_first", 64'(out_src), 64'd0);

    // random traffic obeying hold-until-ready
    in_valid = '0;
    for (int i = 0; i < N; i++) waits[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!in_valid[i] && $urandom_range(0, 2) == 0) begin
          in_valid[i] = 1'b1;
          in_bits[i].idx       = 6'($urandom);
          in_bits[i].coh_state = 2'($urandom);
          in_bits[i].tag       = 20'($urandom);
          if ($urandom_range(0, 63) == 0)
            in_bits[i].way_en = 8'($urandom);
          else
            in_bits[i].way_en = 8'(1 << $urandom_range(0, 7));
          waits[i] = 0;
        end
      end
      cycle();
      for (int i = 0; i < N; i++) begin
        if (fired[i]) begin
          chk("fairness", 64'(waits[i] < N), 64'h1);
          in_valid[i] = 1'b0;
        end else if (in_valid[i] && |fired) begin
          waits[i]++;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
